sff_pipe: RTL and testbench

Parametrised successor to the single-bit preset flop. A WIDTH-bit, DEPTH-stage register pipeline with per-stage valid flags, a valid/ready handshake, bubble collapsing, and a synchronous preset that loads a programmable value into every stage. It is used by techmap as the sequential primitive for multi-cycle data delays that need backpressure.

---
 rtl/sff_pipe_pkg.sv | 12 +
 rtl/sff_pipe_stage.sv | 29 ++
 rtl/sff_pipe.sv | 91 +++++++++
 tb/tb_sff_pipe.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sff_pipe_pkg.sv
// rtl/sff_pipe_pkg.sv - shared helpers and priority codes for the sff_pipe register pipeline
package sff_pipe_pkg;

    localparam logic [1:0] PRI_RESET = 2'd0;
    localparam logic [1:0] PRI_SET   = 2'd1;
    localparam logic [1:0] PRI_RUN   = 2'd2;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sff_pipe_stage.sv
// rtl/sff_pipe_stage.sv - one valid+data register of the sff_pipe pipeline
module sff_pipe_stage #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             load,
    input  logic             vin,
    input  logic [WIDTH-1:0] din,
    output logic             vout,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk) begin
        if (reset) begin
            vout <= 1'b0;
            dout <= '0;
        end else if (set) begin
            vout <= 1'b1;
            dout <= SET_VAL;
        end else if (load) begin
            vout <= vin;
            dout <= din;
        end
    end

endmodule

// File: rtl/sff_pipe.sv
// rtl/sff_pipe.sv - WIDTH x DEPTH valid/ready register pipeline with bubble collapse and preset; optional SFF_PIPE_BYPASS_EN
module sff_pipe
    import sff_pipe_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}}
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      set,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int CW = cnt_w(DEPTH);

    logic             v [DEPTH];
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] adv;
    logic             run;
    logic             bypass;
    logic             in_hs;
    logic             out_hs;
    logic [1:0]       pri;

    assign run = ~reset & ~set;
    assign pri = reset ? PRI_RESET : (set ? PRI_SET : PRI_RUN);

    // A stage can load when it is empty or its occupant moves on, so bubbles collapse.
    always_comb begin
        adv            = '0;
        adv[DEPTH-1]   = out_ready | ~v[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = ~v[i] | adv[i+1];
        end
    end

`ifdef SFF_PIPE_BYPASS_EN
    assign bypass    = run & in_valid & out_ready & (count == '0);
    assign out_valid = v[DEPTH-1] | bypass;
    assign out_data  = bypass ? in_data : d[DEPTH-1];
`else
    assign bypass    = 1'b0;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
`endif

    assign in_ready = run & adv[0];
    assign in_hs    = in_valid & in_ready & ~bypass;
    assign out_hs   = v[DEPTH-1] & out_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            sff_pipe_stage #(.WIDTH(WIDTH), .SET_VAL(SET_VAL)) u_stage (
                .clk(clk), .reset(reset), .set(set), .load(adv[g]),
                .vin(in_hs), .din(in_data), .vout(v[g]), .dout(d[g])
            );
        end else begin : g_body
            sff_pipe_stage #(.WIDTH(WIDTH), .SET_VAL(SET_VAL)) u_stage (
                .clk(clk), .reset(reset), .set(set), .load(adv[g]),
                .vin(v[g-1]), .din(d[g-1]), .vout(v[g]), .dout(d[g])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (set) begin
            count <= CW'(DEPTH);
        end else if (in_hs & ~out_hs) begin
            count <= count + CW'(1);
        end else if (out_hs & ~in_hs) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        assert (pri == PRI_RUN || !in_ready);
        if (pri == PRI_RUN) begin
            assert (count <= CW'(DEPTH));
        end
    end

endmodule

// File: tb/tb_sff_pipe.sv
// tb/tb_sff_pipe.sv - self-checking bench for sff_pipe: directed vector table plus randomized run against a queue model
module tb_sff_pipe;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 3;
    localparam logic [7:0] SV    = 8'h5A;
    localparam int         CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset, set, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]    in_data, out_data;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    sff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SET_VAL(SV)) dut (
        .clk(clk), .reset(reset), .set(set),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         r, s, iv;
        logic [7:0] id;
        bit         o;
        bit         ir, ov, chk_od;
        logic [7:0] od;
        int         cnt;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        int         pos;
    } item_t;

    vec_t  tbl [$];
    item_t q   [$];

    function automatic vec_t mk(bit r, bit s, bit iv, logic [7:0] id, bit o,
                                bit ir, bit ov, bit chk_od, logic [7:0] od, int cnt);
        vec_t t;
        t.r = r; t.s = s; t.iv = iv; t.id = id; t.o = o;
        t.ir = ir; t.ov = ov; t.chk_od = chk_od; t.od = od; t.cnt = cnt;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit s, input bit iv, input logic [7:0] id, input bit o);
        @(negedge clk);
        reset = r; set = s; in_valid = iv; in_data = id; out_ready = o;
        #1;
    endtask

    task automatic model_cycle(input bit r, input bit s, input bit iv, input logic [7:0] id, input bit o);
        bit         run, hv, byp, busy, e_ir, e_ov;
        logic [7:0] e_od;
        int         popped;
        int         np [$];
        drive(r, s, iv, id, o);
        run = !r && !s;
        hv  = q.size() > 0 && q[0].pos == DEPTH - 1;
        byp = 1'b0;
`ifdef SFF_PIPE_BYPASS_EN
        byp = run && iv && o && q.size() == 0;
`endif
        e_ov   = hv || byp;
        e_od   = byp ? id : (hv ? q[0].data : 8'h00);
        popped = (hv && o) ? 1 : 0;
        busy   = 1'b0;
        for (int k = popped; k < q.size(); k++) begin
            int lim, p;
            lim = DEPTH - 1 - (k - popped);
            p   = q[k].pos + 1;
            if (p > lim) p = lim;
            np.push_back(p);
            if (p == 0) busy = 1'b1;
        end
        e_ir = run && !busy;
        chk("rnd in_ready", 32'(in_ready), 32'(e_ir));
        chk("rnd out_valid", 32'(out_valid), 32'(e_ov));
        chk("rnd count", 32'(count), 32'(q.size()));
        if (e_ov) chk("rnd out_data", 32'(out_data), 32'(e_od));
        @(posedge clk);
        if (r) begin
            q.delete();
        end else if (s) begin
            q.delete();
            for (int k = 0; k < DEPTH; k++) q.push_back('{SV, DEPTH - 1 - k});
        end else begin
            if (popped == 1) void'(q.pop_front());
            for (int k = 0; k < q.size(); k++) q[k].pos = np[k];
            if (iv && e_ir && !byp) q.push_back('{id, 0});
        end
    endtask

    initial begin
        reset = 1'b1; set = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // streaming with out_ready high
        tbl.push_back(mk(0,0,1,8'h01,1, 1,0,0,8'h00,0));
        tbl.push_back(mk(0,0,1,8'h02,1, 1,0,0,8'h00,1));
        tbl.push_back(mk(0,0,1,8'h03,1, 1,0,0,8'h00,2));
        tbl.push_back(mk(0,0,1,8'h04,1, 1,1,1,8'h01,3));
        tbl.push_back(mk(0,0,1,8'h05,1, 1,1,1,8'h02,3));
        tbl.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'h03,3));
        tbl.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'h04,2));
        tbl.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'h05,1));
        tbl.push_back(mk(0,0,0,8'h00,0, 1,0,0,8'h00,0));
        // backpressure with an input gap, packing toward the output
        tbl.push_back(mk(0,0,1,8'hA1,0, 1,0,0,8'h00,0));
        tbl.push_back(mk(0,0,0,8'h00,0, 1,0,0,8'h00,1));
        tbl.push_back(mk(0,0,1,8'hA2,0, 1,0,0,8'h00,1));
        tbl.push_back(mk(0,0,0,8'h00,0, 1,1,1,8'hA1,2));
        tbl.push_back(mk(0,0,0,8'h00,0, 1,1,1,8'hA1,2));
        tbl.push_back(mk(0,0,1,8'hA3,0, 1,1,1,8'hA1,2));
        tbl.push_back(mk(0,0,1,8'hA4,0, 0,1,1,8'hA1,3));
        tbl.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'hA1,3));
        tbl.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'hA2,2));
        tbl.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'hA3,1));
        tbl.push_back(mk(0,0,0,8'h00,1, 1,0,0,8'h00,0));
        // reset held two cycles mid-stream
        tbl.push_back(mk(0,0,1,8'hB1,0, 1,0,0,8'h00,0));
        tbl.push_back(mk(0,0,1,8'hB2,0, 1,0,0,8'h00,1));
        tbl.push_back(mk(1,0,1,8'hB3,0, 0,0,0,8'h00,2));
        tbl.push_back(mk(1,0,1,8'hB4,0, 0,0,1,8'h00,0));
        tbl.push_back(mk(0,0,0,8'h00,0, 1,0,1,8'h00,0));
        // set with two items held and in_valid high
        tbl.push_back(mk(0,0,1,8'hC1,0, 1,0,0,8'h00,0));
        tbl.push_back(mk(0,0,1,8'hC2,0, 1,0,0,8'h00,1));
        tbl.push_back(mk(0,1,1,8'hC3,0, 0,0,0,8'h00,2));
        tbl.push_back(mk(0,0,1,8'hC4,0, 0,1,1,8'h5A,3));
        tbl.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'h5A,3));
        tbl.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'h5A,2));
        tbl.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'h5A,1));
        tbl.push_back(mk(0,0,0,8'h00,1, 1,0,0,8'h00,0));
        // reset and set together: reset wins
        tbl.push_back(mk(0,0,1,8'hD1,0, 1,0,0,8'h00,0));
        tbl.push_back(mk(1,1,0,8'h00,0, 0,0,0,8'h00,1));
        tbl.push_back(mk(0,0,0,8'h00,0, 1,0,1,8'h00,0));
        // set on a full pipe with out_ready high discards the head
        tbl.push_back(mk(0,0,1,8'hE1,0, 1,0,0,8'h00,0));
        tbl.push_back(mk(0,0,1,8'hE2,0, 1,0,0,8'h00,1));
        tbl.push_back(mk(0,0,1,8'hE3,0, 1,0,0,8'h00,2));
        tbl.push_back(mk(0,1,0,8'h00,1, 0,1,1,8'hE1,3));
        tbl.push_back(mk(0,0,0,8'h00,0, 0,1,1,8'h5A,3));

        drive(1, 0, 0, 8'h00, 0);
        drive(1, 0, 0, 8'h00, 0);

`ifndef SFF_PIPE_BYPASS_EN
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].iv, tbl[i].id, tbl[i].o);
            chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("row%0d count", i), 32'(count), 32'(tbl[i].cnt));
            if (tbl[i].chk_od) chk($sformatf("row%0d out_data", i), 32'(out_data), 32'(tbl[i].od));
        end
`else
        drive(0, 0, 1, 8'h33, 1);
        chk("bypass out_valid", 32'(out_valid), 32'd1);
        chk("bypass out_data", 32'(out_data), 32'h33);
        chk("bypass in_ready", 32'(in_ready), 32'd1);
        chk("bypass count", 32'(count), 32'd0);
        drive(0, 0, 0, 8'h00, 1);
        chk("bypass after out_valid", 32'(out_valid), 32'd0);
        chk("bypass after count", 32'(count), 32'd0);
`endif

        drive(1, 0, 0, 8'h00, 0);
        @(posedge clk);
        q.delete();

        for (int n = 0; n < 3000; n++) begin
            bit r, s, iv, o;
            r  = ($urandom_range(0, 99) == 0);
            s  = ($urandom_range(0, 79) == 0);
            iv = ($urandom_range(0, 3) != 0);
            o  = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            model_cycle(r, s, iv, 8'($urandom), o);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
